// File: rtl/itch_pkg.sv
// Shared ITCH decode definitions: source IDs, message type codes and the
// per-decoder result layouts that are zero-extended onto the result bus.
package itch_pkg;

  localparam int SRC_ADD     = 0;
  localparam int SRC_CANCEL  = 1;
  localparam int SRC_DELETE  = 2;
  localparam int SRC_REPLACE = 3;
  localparam int SRC_EXEC    = 4;
  localparam int SRC_EXEC_PX = 5;

  localparam logic [7:0] TYPE_ADD     = 8'h41;  // 'A'
  localparam logic [7:0] TYPE_CANCEL  = 8'h58;  // 'X'
  localparam logic [7:0] TYPE_DELETE  = 8'h44;  // 'D'
  localparam logic [7:0] TYPE_REPLACE = 8'h55;  // 'U'
  localparam logic [7:0] TYPE_EXEC    = 8'h45;  // 'E'
  localparam logic [7:0] TYPE_EXEC_PX = 8'h43;  // 'C'

  typedef struct packed {
    logic [63:0] order_ref;
    logic [31:0] shares;
    logic [31:0] price;
  } add_result_t;

  typedef struct packed {
    logic [63:0] order_ref;
    logic [31:0] canceled_shares;
  } cancel_result_t;

  typedef struct packed {
    logic [63:0] order_ref;
  } delete_result_t;

  typedef struct packed {
    logic [63:0] orig_ref;
    logic [63:0] new_ref;
  } replace_result_t;

  typedef struct packed {
    logic [63:0] order_ref;
    logic [31:0] executed_shares;
  } exec_result_t;

  typedef struct packed {
    logic [63:0] order_ref;
    logic [31:0] executed_shares;
    logic [31:0] price;
  } exec_px_result_t;

  function automatic logic [7:0] type_of_src(input int src);
    case (src)
      SRC_ADD:     return TYPE_ADD;
      SRC_CANCEL:  return TYPE_CANCEL;
      SRC_DELETE:  return TYPE_DELETE;
      SRC_REPLACE: return TYPE_REPLACE;
      SRC_EXEC:    return TYPE_EXEC;
      default:     return TYPE_EXEC_PX;
    endcase
  endfunction

endpackage

// File: rtl/itch_decode_arbiter_rr_arbiter.sv
// Round-robin arbiter: first requester at or after rr_ptr wins; the pointer
// moves just past the winner whenever a grant is consumed.
module rr_arbiter
  import itch_pkg::*;
#(
  parameter int NUM_SRC = 6,
  localparam int SRC_W  = $clog2(NUM_SRC)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_SRC-1:0] req,
  input  logic               advance,
  output logic [NUM_SRC-1:0] grant,
  output logic [SRC_W-1:0]   winner,
  output logic               any_req
);

  logic [SRC_W-1:0] rr_ptr;

  always_comb begin
    int idx;
    idx     = 0;
    grant   = '0;
    winner  = '0;
    any_req = 1'b0;
    for (int k = 0; k < NUM_SRC; k++) begin
      idx = (int'(rr_ptr) + k) % NUM_SRC;
      if (!any_req && req[idx]) begin
        any_req    = 1'b1;
        grant[idx] = 1'b1;
        winner     = SRC_W'(idx);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rr_ptr <= '0;
    end else if (advance && any_req) begin
      rr_ptr <= (winner == SRC_W'(NUM_SRC - 1)) ? '0 : winner + 1'b1;
    end
  end

endmodule

// File: rtl/itch_decode_arbiter.sv
// Buffers one-cycle decoder results in per-source slots and round-robins them
// onto a single valid/ready result bus, tracking drops and packet errors.
module itch_decode_arbiter
  import itch_pkg::*;
#(
  parameter int NUM_SRC   = 6,
  parameter int PAYLOAD_W = 128,
  parameter int CNT_W     = 16,
  localparam int SRC_W    = $clog2(NUM_SRC)
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [NUM_SRC-1:0]             src_valid,
  input  logic [NUM_SRC-1:0]             src_invalid,
  input  logic [NUM_SRC*PAYLOAD_W-1:0]   src_payload,
  output logic                           out_valid,
  input  logic                           out_ready,
  output logic [SRC_W-1:0]               out_src,
  output logic [PAYLOAD_W-1:0]           out_payload,
  output logic [NUM_SRC-1:0]             overflow,
  output logic [NUM_SRC-1:0]             invalid_seen,
  output logic [CNT_W-1:0]               drop_count,
  input  logic                           clear_status
);

  logic [NUM_SRC-1:0]   pending;
  logic [NUM_SRC-1:0]   grant;
  logic [NUM_SRC-1:0]   capture;
  logic [NUM_SRC-1:0]   drop;
  logic [PAYLOAD_W-1:0] slot [NUM_SRC];
  logic [SRC_W-1:0]     winner;
  logic                 any_req;
  logic                 load;

  assign load = any_req && (!out_valid || out_ready);

  rr_arbiter #(.NUM_SRC(NUM_SRC)) u_rr_arbiter (
    .clk     (clk),
    .rst     (rst),
    .req     (pending),
    .advance (load),
    .grant   (grant),
    .winner  (winner),
    .any_req (any_req)
  );

  // A full slot still accepts a pulse when its content leaves this very cycle.
  always_comb begin
    capture = '0;
    drop    = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      if (src_valid[i] && !src_invalid[i]) begin
        capture[i] = !pending[i] || (load && grant[i]);
        drop[i]    = pending[i] && !(load && grant[i]);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pending <= '0;
      for (int i = 0; i < NUM_SRC; i++) slot[i] <= '0;
    end else begin
      for (int i = 0; i < NUM_SRC; i++) begin
        if (capture[i]) begin
          pending[i] <= 1'b1;
          slot[i]    <= src_payload[i*PAYLOAD_W +: PAYLOAD_W];
        end else if (load && grant[i]) begin
          pending[i] <= 1'b0;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid   <= 1'b0;
      out_src     <= '0;
      out_payload <= '0;
    end else if (load) begin
      out_valid   <= 1'b1;
      out_src     <= winner;
      out_payload <= slot[winner];
    end else if (out_ready) begin
      out_valid   <= 1'b0;
    end
  end

  // New events take priority over a simultaneous clear.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      overflow     <= '0;
      invalid_seen <= '0;
      drop_count   <= '0;
    end else begin
      overflow     <= (clear_status ? '0 : overflow) | drop;
      invalid_seen <= (clear_status ? '0 : invalid_seen) | src_invalid;
      if (|drop) begin
        if (clear_status)     drop_count <= CNT_W'(1);
        else if (!(&drop_count)) drop_count <= drop_count + 1'b1;
      end else if (clear_status) begin
        drop_count <= '0;
      end
    end
  end

endmodule

// File: tb/tb_itch_decode_arbiter.sv
// Self-checking bench: directed vector table, hand-written corner sequences and
// randomized traffic compared every cycle against a behavioural model.
module tb_itch_decode_arbiter;

  localparam int NS = 6;
  localparam int PW = 128;
  localparam int CW = 4;
  localparam int CNT_MAX = (1 << CW) - 1;

  logic              clk = 1'b0;
  logic              rst;
  logic [NS-1:0]     src_valid;
  logic [NS-1:0]     src_invalid;
  logic [NS*PW-1:0]  src_payload;
  logic              out_valid;
  logic              out_ready;
  logic [2:0]        out_src;
  logic [PW-1:0]     out_payload;
  logic [NS-1:0]     overflow;
  logic [NS-1:0]     invalid_seen;
  logic [CW-1:0]     drop_count;
  logic              clear_status;

  itch_decode_arbiter #(.NUM_SRC(NS), .PAYLOAD_W(PW), .CNT_W(CW)) dut (
    .clk          (clk),
    .rst          (rst),
    .src_valid    (src_valid),
    .src_invalid  (src_invalid),
    .src_payload  (src_payload),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_src      (out_src),
    .out_payload  (out_payload),
    .overflow     (overflow),
    .invalid_seen (invalid_seen),
    .drop_count   (drop_count),
    .clear_status (clear_status)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Behavioural model: one-deep buffer per source, a held output item,
  // a rotating search start, sticky flags and a saturating counter.
  bit           m_pend [NS];
  logic [PW-1:0] m_slot [NS];
  bit           m_ov;
  int           m_src;
  logic [PW-1:0] m_pay;
  int           m_ptr;
  logic [NS-1:0] m_ovf;
  logic [NS-1:0] m_inv;
  int           m_cnt;

  task automatic chk(input string name, input logic [PW-1:0] act, input logic [PW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < NS; i++) begin
      m_pend[i] = 0;
      m_slot[i] = '0;
    end
    m_ov = 0; m_src = 0; m_pay = '0; m_ptr = 0;
    m_ovf = '0; m_inv = '0; m_cnt = 0;
  endtask

  task automatic model_step();
    int win;
    logic [NS-1:0] cap, drp;
    win = -1;
    cap = '0;
    drp = '0;
    if (!m_ov || out_ready) begin
      for (int k = 0; k < NS; k++) begin
        int idx;
        idx = (m_ptr + k) % NS;
        if (win < 0 && m_pend[idx]) win = idx;
      end
    end
    for (int i = 0; i < NS; i++) begin
      if (src_valid[i] && !src_invalid[i]) begin
        if (!m_pend[i] || i == win) cap[i] = 1'b1;
        else drp[i] = 1'b1;
      end
    end
    if (win >= 0) begin
      m_ov = 1; m_src = win; m_pay = m_slot[win];
      m_pend[win] = 0; m_ptr = (win + 1) % NS;
    end else if (out_ready) begin
      m_ov = 0;
    end
    for (int i = 0; i < NS; i++) begin
      if (cap[i]) begin
        m_pend[i] = 1;
        m_slot[i] = src_payload[i*PW +: PW];
      end
    end
    if (clear_status) begin
      m_ovf = '0; m_inv = '0; m_cnt = 0;
    end
    m_ovf |= drp;
    m_inv |= src_invalid;
    if (drp != '0 && m_cnt < CNT_MAX) m_cnt++;
  endtask

  task automatic compare_all();
    chk("out_valid", 128'(out_valid), 128'(m_ov));
    chk("out_src", 128'(out_src), 128'(m_src));
    chk("out_payload", out_payload, m_pay);
    chk("overflow", 128'(overflow), 128'(m_ovf));
    chk("invalid_seen", 128'(invalid_seen), 128'(m_inv));
    chk("drop_count", 128'(drop_count), 128'(m_cnt));
  endtask

  // Drive one cycle of inputs, clock, update model, compare 1 time unit later.
  task automatic cyc(input logic [NS-1:0] v, input logic [NS-1:0] inv,
                     input bit rdy, input bit clr, input logic [63:0] base);
    src_valid    = v;
    src_invalid  = inv;
    out_ready    = rdy;
    clear_status = clr;
    for (int i = 0; i < NS; i++) src_payload[i*PW +: PW] = {8'(i), 56'h0, base};
    @(posedge clk);
    model_step();
    #1;
    compare_all();
  endtask

  typedef struct {
    logic [NS-1:0] valid;
    logic [63:0]   pay;
    bit            exp_valid;
    int            exp_src;
    logic [63:0]   exp_pay;
  } vec_t;

  vec_t vecs [19];

  localparam logic [63:0] P_DEL = 64'h0123_4567_89AB_CDEF;
  localparam logic [63:0] P_Q   = 64'hA5A5_0000_1111_2222;
  localparam logic [63:0] P_R   = 64'h5A5A_3333_4444_5555;

  initial begin
    logic [NS-1:0] rv, ri;
    vecs[0]  = '{6'h3F, P_Q,   0, 0, 64'h0};
    for (int k = 1; k <= 6; k++) vecs[k] = '{6'h00, 64'h0, 1, k - 1, P_Q};
    vecs[7]  = '{6'h00, 64'h0, 0, 0, 64'h0};
    vecs[8]  = '{6'h3F, P_R,   0, 0, 64'h0};
    for (int k = 9; k <= 14; k++) vecs[k] = '{6'h00, 64'h0, 1, k - 9, P_R};
    vecs[15] = '{6'h00, 64'h0, 0, 0, 64'h0};
    vecs[16] = '{6'h04, P_DEL, 0, 0, 64'h0};
    vecs[17] = '{6'h00, 64'h0, 1, 2, P_DEL};
    vecs[18] = '{6'h00, 64'h0, 0, 0, 64'h0};

    rst = 1'b1;
    src_valid = '0; src_invalid = '0; src_payload = '0;
    out_ready = 1'b1; clear_status = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    compare_all();

    // Fairness bursts then single delete, all with out_ready=1.
    for (int k = 0; k < 19; k++) begin
      cyc(vecs[k].valid, '0, 1, 0, vecs[k].pay);
      chk("vec_valid", 128'(out_valid), 128'(vecs[k].exp_valid));
      if (vecs[k].exp_valid) begin
        chk("vec_src", 128'(out_src), 128'(vecs[k].exp_src));
        chk("vec_pay", 128'(out_payload[63:0]), 128'(vecs[k].exp_pay));
      end
      chk("vec_no_overflow", 128'(overflow), 128'(0));
    end

    // Back-pressure on source 1.
    cyc(6'h02, '0, 0, 0, 64'hAAAA);
    cyc(6'h00, '0, 0, 0, 64'h0);
    cyc(6'h02, '0, 0, 0, 64'hBBBB);
    cyc(6'h02, '0, 0, 0, 64'hCCCC);
    repeat (6) cyc(6'h00, '0, 0, 0, 64'h0);
    chk("bp_overflow1", 128'(overflow), 128'(6'h02));
    chk("bp_drop_count", 128'(drop_count), 128'(1));
    chk("bp_held_pay", 128'(out_payload[63:0]), 128'(64'hAAAA));
    cyc(6'h00, '0, 1, 0, 64'h0);
    chk("bp_second_pay", 128'(out_payload[63:0]), 128'(64'hBBBB));
    chk("bp_second_src", 128'(out_src), 128'(1));
    cyc(6'h00, '0, 1, 0, 64'h0);
    chk("bp_drained", 128'(out_valid), 128'(0));
    cyc(6'h00, '0, 1, 1, 64'h0);
    chk("clr_overflow", 128'(overflow), 128'(0));
    chk("clr_drop_count", 128'(drop_count), 128'(0));

    // Grant/capture collision on source 3.
    cyc(6'h08, '0, 1, 0, 64'hD0D0);
    cyc(6'h08, '0, 1, 0, 64'hE0E0);
    chk("coll_no_overflow", 128'(overflow[3]), 128'(0));
    chk("coll_first", 128'(out_payload[63:0]), 128'(64'hD0D0));
    cyc(6'h00, '0, 1, 0, 64'h0);
    chk("coll_second", 128'(out_payload[63:0]), 128'(64'hE0E0));
    chk("coll_second_src", 128'(out_src), 128'(3));
    cyc(6'h00, '0, 1, 0, 64'h0);

    // Invalid packet handling and clear-vs-event priority.
    cyc(6'h01, 6'h01, 1, 0, 64'hF0F0);
    chk("inv_seen", 128'(invalid_seen), 128'(6'h01));
    cyc(6'h00, '0, 1, 0, 64'h0);
    chk("inv_no_output", 128'(out_valid), 128'(0));
    cyc(6'h00, 6'h01, 1, 1, 64'h0);
    chk("inv_beats_clear", 128'(invalid_seen), 128'(6'h01));

    // Drop in the same cycle as clear: counter restarts at 1.
    cyc(6'h04, '0, 0, 0, 64'h1);
    cyc(6'h04, '0, 0, 0, 64'h2);
    cyc(6'h04, '0, 0, 0, 64'h3);
    chk("drop_before_clear", 128'(drop_count), 128'(1));
    cyc(6'h04, '0, 0, 1, 64'h4);
    chk("drop_beats_clear", 128'(drop_count), 128'(1));
    chk("drop_clear_ovf", 128'(overflow), 128'(6'h04));
    chk("drop_clear_inv", 128'(invalid_seen), 128'(0));
    repeat (3) cyc(6'h00, '0, 1, 0, 64'h0);

    // Asynchronous reset with a held result and several pending slots.
    cyc(6'h3F, '0, 0, 0, 64'h7777);
    cyc(6'h00, '0, 0, 0, 64'h0);
    chk("pre_rst_valid", 128'(out_valid), 128'(1));
    #2 rst = 1'b1;
    #1 chk("rst_async_valid", 128'(out_valid), 128'(0));
    @(posedge clk);
    #1 rst = 1'b0;
    model_reset();
    compare_all();
    cyc(6'h3F, '0, 1, 0, 64'h8888);
    cyc(6'h00, '0, 1, 0, 64'h0);
    chk("rst_ptr_zero", 128'(out_src), 128'(0));
    repeat (6) cyc(6'h00, '0, 1, 0, 64'h0);

    // Random traffic: heavy back-pressure first (drives drop_count to saturation).
    for (int n = 0; n < 120; n++) begin
      rv = NS'($urandom);
      ri = ($urandom_range(0, 15) == 0) ? NS'(1 << $urandom_range(0, NS - 1)) : '0;
      cyc(rv, ri, $urandom_range(0, 3) == 0, 0, {$urandom, $urandom});
    end
    chk("drop_saturated", 128'(drop_count), 128'(CNT_MAX));
    for (int n = 0; n < 400; n++) begin
      rv = NS'($urandom) & NS'($urandom);
      ri = ($urandom_range(0, 15) == 0) ? NS'(1 << $urandom_range(0, NS - 1)) : '0;
      cyc(rv, ri, $urandom_range(0, 3) != 0, $urandom_range(0, 31) == 0,
          {$urandom, $urandom});
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
